// File: rtl/xbar_ptr_gen_param_pkg.sv
// Shared crossbar type/parameter package used by the reorder-storage pointer generator.
// Default geometry lives here so the top level and any user agree on sizing.
package mpc_types;

    localparam int XBAR_NUM_CH    = 3;
    localparam int XBAR_NUM_BANK  = 4;
    localparam int XBAR_DEPTH     = 8;
    localparam int XBAR_AFULL_TH  = 6;

    typedef logic [$clog2(XBAR_DEPTH)-1:0] xbar_ptr_t;
    typedef logic [$clog2(XBAR_DEPTH):0]   xbar_cnt_t;

endpackage

// File: rtl/xbar_ch_ptr_ctrl.sv
// Single-channel slot ring controller: write/read pointers, occupancy and status.
// A slot retires only when every bank reports it popped; flush wipes the channel.
module xbar_ch_ptr_ctrl
    import mpc_types::*;
#(
    parameter  int NUM_BANK = XBAR_NUM_BANK,
    parameter  int DEPTH    = XBAR_DEPTH,
    parameter  int AFULL_TH = XBAR_AFULL_TH,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_reqValid,
    input  logic [NUM_BANK-1:0] i_bankPopDone,
    input  logic                i_flush,
    output logic                o_reqReady,
    output logic                o_popAck,
    output logic [PTR_W-1:0]    o_wPtr,
    output logic [PTR_W-1:0]    o_rPtr,
    output logic [CNT_W-1:0]    o_usedCnt,
    output logic                o_full,
    output logic                o_empty,
    output logic                o_afull,
    output logic                o_underflowErr
);

    localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_LVL = CNT_W'(AFULL_TH);

    logic [PTR_W-1:0] r_wPtr;
    logic [PTR_W-1:0] r_rPtr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_uflow;

    logic             w_full;
    logic             w_empty;
    logic             w_allPop;
    logic             w_push;
    logic             w_pop;
    logic             w_uflowSet;

    logic             w_wPtrEn;
    logic [PTR_W-1:0] w_wPtrNxt;
    logic             w_rPtrEn;
    logic [PTR_W-1:0] w_rPtrNxt;
    logic             w_cntEn;
    logic [CNT_W-1:0] w_cntNxt;
    logic             w_uflowEn;
    logic             w_uflowNxt;

    assign w_full     = (r_cnt == FULL_LVL);
    assign w_empty    = (r_cnt == '0);
    assign w_allPop   = &i_bankPopDone;

    // Ready looks only at registered state so a pop cannot make room in the same cycle.
    assign o_reqReady = ~w_full & ~i_flush & rst_n;
    assign w_push     = i_reqValid & o_reqReady;
    assign w_pop      = w_allPop & ~w_empty & ~i_flush & rst_n;
    assign w_uflowSet = w_allPop & w_empty & ~i_flush;

    assign w_wPtrEn   = i_flush | w_push;
    assign w_wPtrNxt  = i_flush ? '0 : r_wPtr + PTR_W'(1);
    assign w_rPtrEn   = i_flush | w_pop;
    assign w_rPtrNxt  = i_flush ? '0 : r_rPtr + PTR_W'(1);

    // Push and pop together cancel out, so the counter only moves when exactly one happens.
    assign w_cntEn    = i_flush | (w_push ^ w_pop);
    assign w_cntNxt   = i_flush ? '0 : (w_push ? r_cnt + CNT_W'(1) : r_cnt - CNT_W'(1));
    assign w_uflowEn  = i_flush | w_uflowSet;
    assign w_uflowNxt = ~i_flush;

    always_ff @(posedge clk) begin
        if (!rst_n)        r_wPtr <= '0;
        else if (w_wPtrEn) r_wPtr <= w_wPtrNxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)        r_rPtr <= '0;
        else if (w_rPtrEn) r_rPtr <= w_rPtrNxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       r_cnt <= '0;
        else if (w_cntEn) r_cnt <= w_cntNxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)         r_uflow <= 1'b0;
        else if (w_uflowEn) r_uflow <= w_uflowNxt;
    end

    assign o_popAck       = w_pop;
    assign o_wPtr         = r_wPtr;
    assign o_rPtr         = r_rPtr;
    assign o_usedCnt      = r_cnt;
    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_afull        = (r_cnt >= AFULL_LVL);
    assign o_underflowErr = r_uflow;

endmodule

// File: rtl/xbar_ptr_gen_param.sv
// Per-channel write/read pointer generator for the crossbar reorder storage.
// Replicates one independent ring controller per channel and flattens their buses.
module xbar_ptr_gen_param
    import mpc_types::*;
#(
    parameter  int NUM_CH   = XBAR_NUM_CH,
    parameter  int NUM_BANK = XBAR_NUM_BANK,
    parameter  int DEPTH    = XBAR_DEPTH,
    parameter  int AFULL_TH = XBAR_AFULL_TH,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          req_valid,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic [NUM_CH*NUM_BANK-1:0] bank_pop_done,
    output logic [NUM_CH-1:0]          pop_ack,
    input  logic [NUM_CH-1:0]          flush,
    output logic [NUM_CH*PTR_W-1:0]    w_ptr,
    output logic [NUM_CH*PTR_W-1:0]    r_ptr,
    output logic [NUM_CH*CNT_W-1:0]    used_cnt,
    output logic [NUM_CH-1:0]          full,
    output logic [NUM_CH-1:0]          empty,
    output logic [NUM_CH-1:0]          afull,
    output logic [NUM_CH-1:0]          underflow_err
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        xbar_ch_ptr_ctrl #(
            .NUM_BANK (NUM_BANK),
            .DEPTH    (DEPTH),
            .AFULL_TH (AFULL_TH)
        ) u_ctrl (
            .clk            (clk),
            .rst_n          (rst_n),
            .i_reqValid     (req_valid[c]),
            .i_bankPopDone  (bank_pop_done[c*NUM_BANK +: NUM_BANK]),
            .i_flush        (flush[c]),
            .o_reqReady     (req_ready[c]),
            .o_popAck       (pop_ack[c]),
            .o_wPtr         (w_ptr[c*PTR_W +: PTR_W]),
            .o_rPtr         (r_ptr[c*PTR_W +: PTR_W]),
            .o_usedCnt      (used_cnt[c*CNT_W +: CNT_W]),
            .o_full         (full[c]),
            .o_empty        (empty[c]),
            .o_afull        (afull[c]),
            .o_underflowErr (underflow_err[c])
        );
    end

endmodule

// File: tb/tb_xbar_ptr_gen_param.sv
// Self-checking bench for xbar_ptr_gen_param: fill table, directed corner sequences,
// then random traffic against a push/pop-count model of each channel ring.
module tb_xbar_ptr_gen_param;
    import mpc_types::*;

    localparam int NUM_CH   = 3;
    localparam int NUM_BANK = 4;
    localparam int DEPTH    = 8;
    localparam int AFULL_TH = 6;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    logic                       clk;
    logic                       rst_n;
    logic [NUM_CH-1:0]          req_valid;
    logic [NUM_CH-1:0]          req_ready;
    logic [NUM_CH*NUM_BANK-1:0] bank_pop_done;
    logic [NUM_CH-1:0]          pop_ack;
    logic [NUM_CH-1:0]          flush;
    logic [NUM_CH*PTR_W-1:0]    w_ptr;
    logic [NUM_CH*PTR_W-1:0]    r_ptr;
    logic [NUM_CH*CNT_W-1:0]    used_cnt;
    logic [NUM_CH-1:0]          full;
    logic [NUM_CH-1:0]          empty;
    logic [NUM_CH-1:0]          afull;
    logic [NUM_CH-1:0]          underflow_err;

    xbar_ptr_gen_param #(
        .NUM_CH   (NUM_CH),
        .NUM_BANK (NUM_BANK),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .bank_pop_done (bank_pop_done),
        .pop_ack       (pop_ack),
        .flush         (flush),
        .w_ptr         (w_ptr),
        .r_ptr         (r_ptr),
        .used_cnt      (used_cnt),
        .full          (full),
        .empty         (empty),
        .afull         (afull),
        .underflow_err (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    // Model: a ring is fully described by how many slots were pushed and popped since it was last cleared.
    int mPush [NUM_CH];
    int mPop  [NUM_CH];
    bit mUflow[NUM_CH];

    typedef struct {
        logic [NUM_CH-1:0] valid;
        int expW0;
        int expCnt0;
        int expFull0;
        int expAfull0;
        int expReady0;
    } fill_vec_t;

    fill_vec_t fillTab[10];

    function automatic int getW(int c);
        return int'(w_ptr[c*PTR_W +: PTR_W]);
    endfunction

    function automatic int getR(int c);
        return int'(r_ptr[c*PTR_W +: PTR_W]);
    endfunction

    function automatic int getCnt(int c);
        return int'(used_cnt[c*CNT_W +: CNT_W]);
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < NUM_CH; c++) begin
            mPush[c]  = 0;
            mPop[c]   = 0;
            mUflow[c] = 1'b0;
        end
    endtask

    // Drives one cycle of inputs, checks state and combinational outputs at the negedge,
    // then advances the model across the rising edge. Returns 1ns after that edge.
    task automatic applyStimulus(input bit rst, input logic [NUM_CH-1:0] valid,
                                 input logic [NUM_CH*NUM_BANK-1:0] bpd,
                                 input logic [NUM_CH-1:0] fl);
        int  cnt   [NUM_CH];
        bit  allPop[NUM_CH];
        bit  expRdy[NUM_CH];
        bit  expPop[NUM_CH];
        rst_n         = rst;
        req_valid     = valid;
        bank_pop_done = bpd;
        flush         = fl;
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            cnt[c]    = mPush[c] - mPop[c];
            allPop[c] = &bpd[c*NUM_BANK +: NUM_BANK];
            expRdy[c] = rst && (cnt[c] < DEPTH) && !fl[c];
            expPop[c] = rst && allPop[c] && (cnt[c] > 0) && !fl[c];
            checkOutput($sformatf("w_ptr[%0d]", c), getW(c), mPush[c] % DEPTH);
            checkOutput($sformatf("r_ptr[%0d]", c), getR(c), mPop[c] % DEPTH);
            checkOutput($sformatf("used_cnt[%0d]", c), getCnt(c), cnt[c]);
            checkOutput($sformatf("full[%0d]", c), int'(full[c]), int'(cnt[c] == DEPTH));
            checkOutput($sformatf("empty[%0d]", c), int'(empty[c]), int'(cnt[c] == 0));
            checkOutput($sformatf("afull[%0d]", c), int'(afull[c]), int'(cnt[c] >= AFULL_TH));
            checkOutput($sformatf("underflow_err[%0d]", c), int'(underflow_err[c]), int'(mUflow[c]));
            checkOutput($sformatf("req_ready[%0d]", c), int'(req_ready[c]), int'(expRdy[c]));
            checkOutput($sformatf("pop_ack[%0d]", c), int'(pop_ack[c]), int'(expPop[c]));
        end
        @(posedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            if (!rst || fl[c]) begin
                mPush[c]  = 0;
                mPop[c]   = 0;
                mUflow[c] = 1'b0;
            end else begin
                if (valid[c] && expRdy[c]) mPush[c]++;
                if (expPop[c])             mPop[c]++;
                if (allPop[c] && cnt[c] == 0) mUflow[c] = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [NUM_CH-1:0]          rv;
        logic [NUM_CH*NUM_BANK-1:0] rb;
        logic [NUM_CH-1:0]          rf;
        bit                         rr;

        fillTab[0] = '{3'b001, 1, 1, 0, 0, 1};
        fillTab[1] = '{3'b001, 2, 2, 0, 0, 1};
        fillTab[2] = '{3'b001, 3, 3, 0, 0, 1};
        fillTab[3] = '{3'b001, 4, 4, 0, 0, 1};
        fillTab[4] = '{3'b001, 5, 5, 0, 0, 1};
        fillTab[5] = '{3'b001, 6, 6, 0, 1, 1};
        fillTab[6] = '{3'b001, 7, 7, 0, 1, 1};
        fillTab[7] = '{3'b001, 0, 8, 1, 1, 0};
        fillTab[8] = '{3'b001, 0, 8, 1, 1, 0};
        fillTab[9] = '{3'b001, 0, 8, 1, 1, 0};

        // Reset state
        rst_n         = 1'b0;
        req_valid     = '0;
        bank_pop_done = '0;
        flush         = '0;
        repeat (2) @(posedge clk);
        #1;
        modelReset();
        checkOutput("reset w_ptr", int'(w_ptr), 0);
        checkOutput("reset r_ptr", int'(r_ptr), 0);
        checkOutput("reset used_cnt", int'(used_cnt), 0);
        checkOutput("reset empty", int'(empty), 7);
        checkOutput("reset full", int'(full), 0);
        checkOutput("reset afull", int'(afull), 0);
        checkOutput("reset req_ready", int'(req_ready), 0);
        checkOutput("reset pop_ack", int'(pop_ack), 0);

        // Fill ch0 from the table
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, fillTab[i].valid, '0, '0);
            checkOutput($sformatf("fill%0d w_ptr0", i), getW(0), fillTab[i].expW0);
            checkOutput($sformatf("fill%0d cnt0", i), getCnt(0), fillTab[i].expCnt0);
            checkOutput($sformatf("fill%0d full0", i), int'(full[0]), fillTab[i].expFull0);
            checkOutput($sformatf("fill%0d afull0", i), int'(afull[0]), fillTab[i].expAfull0);
            checkOutput($sformatf("fill%0d ready0", i), int'(req_ready[0]), fillTab[i].expReady0);
        end

        // Partial bank pop on ch1
        repeat (2) applyStimulus(1'b1, 3'b010, '0, '0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, '0, 12'h070, '0);
            checkOutput("partial pop_ack1", int'(pop_ack[1]), 0);
            checkOutput("partial r_ptr1", getR(1), 0);
        end
        applyStimulus(1'b1, '0, 12'h0F0, '0);
        checkOutput("allbank r_ptr1", getR(1), 1);
        checkOutput("allbank cnt1", getCnt(1), 1);
        applyStimulus(1'b1, '0, '0, '0);
        checkOutput("allbank pulse ends", int'(pop_ack[1]), 0);

        // Simultaneous push/pop on ch2
        repeat (5) applyStimulus(1'b1, 3'b100, '0, '0);
        repeat (2) applyStimulus(1'b1, '0, 12'hF00, '0);
        checkOutput("pp pre w_ptr2", getW(2), 5);
        checkOutput("pp pre r_ptr2", getR(2), 2);
        checkOutput("pp pre cnt2", getCnt(2), 3);
        applyStimulus(1'b1, 3'b100, 12'hF00, '0);
        checkOutput("pp w_ptr2", getW(2), 6);
        checkOutput("pp r_ptr2", getR(2), 3);
        checkOutput("pp cnt2", getCnt(2), 3);

        // Wrap on ch0: clear, bring both pointers to 7, then push and pop across the wrap
        applyStimulus(1'b1, '0, '0, 3'b001);
        repeat (7) applyStimulus(1'b1, 3'b001, '0, '0);
        repeat (7) applyStimulus(1'b1, '0, 12'h00F, '0);
        checkOutput("wrap pre w_ptr0", getW(0), 7);
        checkOutput("wrap pre r_ptr0", getR(0), 7);
        checkOutput("wrap pre empty0", int'(empty[0]), 1);
        applyStimulus(1'b1, 3'b001, '0, '0);
        checkOutput("wrap w_ptr0", getW(0), 0);
        checkOutput("wrap cnt0", getCnt(0), 1);
        applyStimulus(1'b1, '0, 12'h00F, '0);
        checkOutput("wrap r_ptr0", getR(0), 0);
        checkOutput("wrap cnt0 after pop", getCnt(0), 0);

        // Flush ch1 at occupancy 5 while ch0 pushes, then provoke underflow
        repeat (4) applyStimulus(1'b1, 3'b010, '0, '0);
        checkOutput("flush pre cnt1", getCnt(1), 5);
        applyStimulus(1'b1, 3'b011, 12'h0F0, 3'b010);
        checkOutput("flush w_ptr1", getW(1), 0);
        checkOutput("flush r_ptr1", getR(1), 0);
        checkOutput("flush cnt1", getCnt(1), 0);
        checkOutput("flush ch0 w_ptr", getW(0), 1);
        checkOutput("flush ch0 cnt", getCnt(0), 1);
        applyStimulus(1'b1, '0, 12'h0F0, '0);
        checkOutput("underflow set", int'(underflow_err[1]), 1);
        repeat (3) begin
            applyStimulus(1'b1, '0, '0, '0);
            checkOutput("underflow sticky", int'(underflow_err[1]), 1);
        end
        applyStimulus(1'b1, '0, '0, 3'b010);
        checkOutput("underflow cleared", int'(underflow_err[1]), 0);

        // Reset mid-operation
        repeat (2) applyStimulus(1'b1, 3'b111, '0, '0);
        applyStimulus(1'b0, 3'b111, 12'hFFF, '0);
        checkOutput("midrst used_cnt", int'(used_cnt), 0);
        checkOutput("midrst w_ptr", int'(w_ptr), 0);
        checkOutput("midrst empty", int'(empty), 7);
        checkOutput("midrst req_ready", int'(req_ready), 0);
        checkOutput("midrst pop_ack", int'(pop_ack), 0);
        rst_n     = 1'b1;
        req_valid = '0;
        bank_pop_done = '0;
        #1;
        checkOutput("post-reset req_ready", int'(req_ready), 7);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rr = ($urandom_range(0, 99) != 0);
            rv = NUM_CH'($urandom);
            rf = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                rb[c*NUM_BANK +: NUM_BANK] = ($urandom_range(0, 2) == 0) ? 4'hF : NUM_BANK'($urandom);
                rf[c] = ($urandom_range(0, 31) == 0);
            end
            applyStimulus(rr, rv, rb, rf);
        end
        applyStimulus(1'b1, '0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/xbar_ptr_gen_param.md
Name: xbar_ptr_gen_param

Overview:
- Parametrised per-channel write/read pointer generator for the crossbar reorder storage.
- Serves NUM_CH upstream request channels. Each channel owns a DEPTH-entry circular slot ring that is shared across NUM_BANK banks.
- Per channel:
  - Allocates a write slot on each accepted request.
  - Retires the read slot only once every bank has popped that slot.
  - Exposes occupancy, full/empty and almost-full status, and supports a per-channel flush.
- Uses the full DEPTH capacity. This corrects the previous generation, which lost one entry.
- Handles simultaneous push and pop correctly. The previous generation had incorrect occupancy arithmetic in that case.

Parameters:
- NUM_CH, default 3: number of upstream request channels.
- NUM_BANK, default 4: number of banks whose pop completion gates retirement.
- DEPTH, default 8: slots per channel ring. Must be a power of two, at least 2.
- AFULL_TH, default 6: almost-full assert level; afull when used_cnt is at least AFULL_TH. Must satisfy 1 ≤ AFULL_TH ≤ DEPTH.
- PTR_W, derived as $clog2(DEPTH): pointer width.
- CNT_W, derived as PTR_W+1: occupancy counter width.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: reset. Synchronous, active-low.
- req_valid, input, NUM_CH: per-channel upstream request valid.
- req_ready, output, NUM_CH: per-channel upstream request ready.
- bank_pop_done, input, NUM_CH*NUM_BANK: bank b has popped the current read slot of channel c. Bit index is c*NUM_BANK+b. Level signal.
- pop_ack, output, NUM_CH: one-cycle pulse when a channel's read slot retires. Banks clear their pop_done on this pulse.
- flush, input, NUM_CH: per-channel synchronous flush.
- w_ptr, output, NUM_CH*PTR_W: per-channel write slot index. Channel c occupies bits c*PTR_W +: PTR_W.
- r_ptr, output, NUM_CH*PTR_W: per-channel read slot index. Same packing as w_ptr.
- used_cnt, output, NUM_CH*CNT_W: per-channel occupancy, range 0..DEPTH.
- full, output, NUM_CH: used_cnt == DEPTH.
- empty, output, NUM_CH: used_cnt == 0.
- afull, output, NUM_CH: used_cnt ≥ AFULL_TH.
- underflow_err, output, NUM_CH: sticky. Set when all bank_pop_done bits are high while the channel is empty. Cleared only by reset or by flush of that channel.

Behaviour:
- Reset (rst_n low at a rising edge):
  - w_ptr, r_ptr, used_cnt and underflow_err go to 0; empty=1, full=0.
  - afull is 0 unless AFULL_TH... since AFULL_TH ≥ 1, afull=0.
  - While rst_n is low, req_ready and pop_ack are forced to 0.
- All per-channel logic is independent. No cross-channel interaction.
- push[c] = req_valid[c] & req_ready[c].
- req_ready[c] = ~full[c] & ~flush[c] & rst_n. It is combinational from registered state. There is no dependency on req_valid.
- all_pop[c] = AND of bank_pop_done[c*NUM_BANK +: NUM_BANK].
- pop[c] = all_pop[c] & ~empty[c] & ~flush[c]. pop_ack[c] = pop[c], combinational, in the same cycle.
- Pointer update, next edge:
  - On push, w_ptr increments.
  - On pop, r_ptr increments.
  - Both wrap from DEPTH-1 to 0 by natural PTR_W-bit overflow.
- used_cnt update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, and both pointers still advance.
  - neither: hold.
- A push is never accepted when used_cnt == DEPTH.
- A pop never occurs when used_cnt == 0.
- Full boundary: a channel that is full with pop=1 keeps req_ready=0 in that same cycle, because ready depends only on registered state. req_ready returns to 1 in the next cycle.
- Invariant: w_ptr == (r_ptr + used_cnt) mod DEPTH at all times.
- Flush[c]:
  - Highest priority below reset.
  - Next edge: w_ptr, r_ptr, used_cnt and underflow_err for that channel go to 0.
  - The request is not accepted and no pop_ack is issued in the flush cycle.
  - Other channels are unaffected.
- Underflow detection: all_pop & empty & ~flush sets underflow_err on the next edge. No state change otherwise.
- Reset or flush asserted mid-stream discards all in-flight slots. No pop_ack is issued for the discarded slots.

Decomposition:
- Shared package mpc_types gains:
  - localparam XBAR_NUM_CH, XBAR_NUM_BANK, XBAR_DEPTH.
  - typedef xbar_ptr_t as logic [$clog2(XBAR_DEPTH)-1:0].
  - typedef xbar_cnt_t as logic [$clog2(XBAR_DEPTH):0].
- One sub-module, xbar_ch_ptr_ctrl (parameters NUM_BANK, DEPTH, AFULL_TH), holds a single channel's counters and status.
- The top level generates NUM_CH instances of xbar_ch_ptr_ctrl and packs and unpacks the flattened buses.
- State registers use ns_gnrl_dfflr-style enable flops with synchronous reset.

Test Plan (defaults: NUM_CH=3, NUM_BANK=4, DEPTH=8, AFULL_TH=6):
- Fill: ch0 valid held for 10 cycles, no pops.
  - 8 accepts; w_ptr sequence 1..7 then 0.
  - used_cnt reaches 8; full=1; req_ready[0]=0 from cycle 8.
  - afull asserts at used_cnt=6.
- Partial bank pop: ch1 holds 2 entries; banks 0-2 done and bank 3 low for 5 cycles.
  - No pop_ack; r_ptr stays 0.
  - Bank 3 rises: pop_ack pulses 1 cycle; r_ptr=1; used_cnt=1.
- Simultaneous push/pop: ch2 at used_cnt=3, w_ptr=5, r_ptr=2, with push and pop in the same cycle.
  - w_ptr=6, r_ptr=3, used_cnt=3.
- Wrap: ch0 w_ptr=7, r_ptr=7, empty; 1 push then 1 pop.
  - w_ptr=0, then r_ptr=0, used_cnt=0.
- Flush and underflow:
  - ch1 with used_cnt=5; flush[1] pulsed while ch0 is pushing. ch1 ptrs and cnt go to 0, with no pop_ack[1]; ch0 is unaffected.
  - Then all ch1 bank_pop_done high while empty: underflow_err[1]=1 and sticky until the next flush[1].
- Reset mid-operation: rst_n low for 1 cycle with all channels partially full.
  - All outputs go to their reset values.
  - req_ready=0 during reset and 1 on the following cycle.
